// File: rtl/arithmetic_unit_if.sv
// arithmetic_unit_if: operand/result bundle for the arithmetic stage
interface arithmetic_unit_if #(
  parameter int A_W = 11,
  parameter int B_W = 8,
  parameter int Y_W = 18
);
  logic           in_valid;
  logic [A_W-1:0] a;
  logic [B_W-1:0] b;
  logic           out_valid;
  logic [A_W-1:0] w;
  logic [A_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [A_W-1:0] z;
  logic           w_carry;
  logic           x_borrow;
  logic           y_ovf;
  logic           div_zero;
  modport master (
    output in_valid, a, b,
    input  out_valid, w, x, y, z, w_carry, x_borrow, y_ovf, div_zero
  );
  modport slave (
    input  in_valid, a, b,
    output out_valid, w, x, y, z, w_carry, x_borrow, y_ovf, div_zero
  );
endinterface

// File: rtl/arithmetic_unit.sv
// arithmetic_unit: registered unsigned add/sub/mul/div stage with status flags
module arithmetic_unit #(
  parameter int A_W = 11,
  parameter int B_W = 8,
  parameter int Y_W = 18
) (
  input logic               clk,
  input logic               rst_n,
  arithmetic_unit_if.slave  io
);
  logic [A_W:0]       sum;
  logic [A_W:0]       diff;
  logic [A_W+B_W-1:0] prod;
  logic [A_W-1:0]     quo;
  logic               b_zero;
  assign sum    = (A_W+1)'(io.a) + (A_W+1)'(io.b);
  assign diff   = (A_W+1)'(io.a) - (A_W+1)'(io.b);
  assign prod   = (A_W+B_W)'(io.a) * (A_W+B_W)'(io.b);
  assign b_zero = io.b == '0;
  assign quo    = b_zero ? '1 : io.a / A_W'(io.b);
  // capture results on valid operands, otherwise hold them and drop out_valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      io.out_valid <= 1'b0;
      io.w         <= '0;
      io.x         <= '0;
      io.y         <= '0;
      io.z         <= '0;
      io.w_carry   <= 1'b0;
      io.x_borrow  <= 1'b0;
      io.y_ovf     <= 1'b0;
      io.div_zero  <= 1'b0;
    end else begin
      io.out_valid <= io.in_valid;
      if (io.in_valid) begin
        io.w        <= sum[A_W-1:0];
        io.x        <= diff[A_W-1:0];
        io.y        <= prod[Y_W-1:0];
        io.z        <= quo;
        io.w_carry  <= sum[A_W];
        io.x_borrow <= A_W'(io.b) > io.a;
        io.y_ovf    <= |prod[A_W+B_W-1:Y_W];
        io.div_zero <= b_zero;
      end
    end
  end
endmodule

// File: tb/tb_arithmetic_unit.sv
// tb_arithmetic_unit: scoreboard bench for the arithmetic stage
module tb_arithmetic_unit;
  typedef struct packed {
    logic [10:0] w;
    logic [10:0] x;
    logic [17:0] y;
    logic [10:0] z;
    logic        wc;
    logic        xb;
    logic        yo;
    logic        dz;
  } res_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  res_t exp_q[$];
  arithmetic_unit_if io ();
  arithmetic_unit dut (.clk(clk), .rst_n(rst_n), .io(io));
  always #5 clk = ~clk;
  function automatic res_t model(int a, int b);
    res_t r;
    r.w  = 11'((a + b) % 2048);
    r.wc = (a + b) > 2047;
    r.x  = 11'((a - b + 2048) % 2048);
    r.xb = b > a;
    r.y  = 18'((a * b) % 262144);
    r.yo = (a * b) >= 262144;
    r.z  = (b == 0) ? 11'd2047 : 11'(a / b);
    r.dz = b == 0;
    return r;
  endfunction
  function automatic res_t mk(int w, int x, int y, int z, bit wc, bit xb, bit yo, bit dz);
    res_t r;
    r.w = 11'(w); r.x = 11'(x); r.y = 18'(y); r.z = 11'(z);
    r.wc = wc; r.xb = xb; r.yo = yo; r.dz = dz;
    return r;
  endfunction
  function automatic res_t actual();
    return {io.w, io.x, io.y, io.z, io.w_carry, io.x_borrow, io.y_ovf, io.div_zero};
  endfunction
  task automatic send(int a, int b, res_t e);
    @(negedge clk);
    io.in_valid = 1'b1;
    io.a = 11'(a);
    io.b = 8'(b);
    exp_q.push_back(e);
  endtask
  // monitor: every presented result is matched against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && io.out_valid) begin
      res_t e;
      res_t got;
      got = actual();
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result got=%h required=none", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL result got w=%0d x=%0d y=%0d z=%0d flags=%b required w=%0d x=%0d y=%0d z=%0d flags=%b",
                   got.w, got.x, got.y, got.z, {got.wc, got.xb, got.yo, got.dz},
                   e.w, e.x, e.y, e.z, {e.wc, e.xb, e.yo, e.dz});
        end
      end
    end
  end
  initial begin
    res_t got;
    io.in_valid = 1'b1;
    io.a = 11'd100;
    io.b = 8'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    got = actual();
    if (io.out_valid !== 1'b0 || got !== '0) begin
      errors++;
      $display("FAIL reset got out_valid=%b res=%h required out_valid=0 res=0", io.out_valid, got);
    end
    io.in_valid = 1'b0;
    rst_n = 1'b1;
    send(1000, 200, mk(1200, 800, 200000, 5, 0, 0, 0, 0));
    send(2047, 255, mk(254, 1792, 259841, 8, 1, 0, 1, 0));
    send(5, 10, mk(15, 2043, 50, 0, 0, 1, 0, 0));
    send(1024, 0, mk(1024, 1024, 0, 2047, 0, 0, 0, 1));
    send(9, 3, mk(12, 6, 27, 3, 0, 0, 0, 0));
    @(negedge clk);
    io.in_valid = 1'b0;
    io.a = 11'd77;
    io.b = 8'd0;
    @(negedge clk);
    checks++;
    got = actual();
    if (io.out_valid !== 1'b0 || got !== mk(12, 6, 27, 3, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL hold got out_valid=%b w=%0d x=%0d y=%0d z=%0d required out_valid=0 w=12 x=6 y=27 z=3",
               io.out_valid, got.w, got.x, got.y, got.z);
    end
    for (int a = 0; a <= 1024; a += 8)
      for (int b = 0; b <= 225; b++)
        send(a, b, model(a, b));
    send(2047, 1, model(2047, 1));
    send(3, 0, model(3, 0));
    @(negedge clk);
    io.in_valid = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got pending=%0d required pending=0", exp_q.size());
    end
    send(600, 7, model(600, 7));
    rst_n = 1'b0;
    @(negedge clk);
    void'(exp_q.pop_back());
    io.in_valid = 1'b0;
    checks++;
    got = actual();
    if (io.out_valid !== 1'b0 || got !== '0) begin
      errors++;
      $display("FAIL midreset got out_valid=%b res=%h required out_valid=0 res=0", io.out_valid, got);
    end
    rst_n = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
